// File: rtl/game_state_nxn_if.sv
// Move/status bundle between the move-entry front end and the game_state_nxn engine.
// The front end (master) drives requests; the engine (slave) publishes board, turn, status and scores.
interface game_state_nxn_if #(
   parameter int N       = 3,
   parameter int SCORE_W = 8,
   parameter int IDX_W   = $clog2(N*N)
);
   logic               new_game;
   logic               move_valid;
   logic [IDX_W-1:0]   move_idx;
   logic               move_ready;
   logic [N*N-1:0]     x_board;
   logic [N*N-1:0]     o_board;
   logic               turn;
   logic [2:0]         status;
   logic               status_valid;
   logic [SCORE_W-1:0] x_wins;
   logic [SCORE_W-1:0] o_wins;

   modport master (
      output new_game, move_valid, move_idx,
      input  move_ready, x_board, o_board, turn, status, status_valid, x_wins, o_wins
   );

   modport slave (
      input  new_game, move_valid, move_idx,
      output move_ready, x_board, o_board, turn, status, status_valid, x_wins, o_wins
   );
endinterface

// File: rtl/game_state_nxn.sv
// Two-player NxN board engine: registered move handshake, one-cell-per-cycle K-in-a-row scan,
// win/draw reporting and per-player saturating win counters.
module game_state_nxn #(
   parameter int N            = 3,
   parameter int K            = 3,
   parameter int SCORE_W      = 8,
   parameter bit FIRST_PLAYER = 1'b1,
   parameter int IDX_W        = $clog2(N*N)
) (
   input logic             clk,
   input logic             rst,
   game_state_nxn_if.slave bus
);

   localparam int CELLS = N*N;
   localparam int CNT_W = $clog2(CELLS+1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_OVER  = 2'd2;

   localparam logic [2:0] ST_PLAY = 3'd0;
   localparam logic [2:0] ST_XWIN = 3'd1;
   localparam logic [2:0] ST_OWIN = 3'd2;
   localparam logic [2:0] ST_DRAW = 3'd3;
   localparam logic [2:0] ST_BAD  = 3'd4;

   logic [1:0]         r_state;
   logic [CELLS-1:0]   r_xBoard;
   logic [CELLS-1:0]   r_oBoard;
   logic               r_turn;
   logic [2:0]         r_status;
   logic               r_statusValid;
   logic [SCORE_W-1:0] r_xWins;
   logic [SCORE_W-1:0] r_oWins;
   logic [CNT_W-1:0]   r_scanCnt;
   logic [CNT_W-1:0]   r_scanRow;
   logic [CNT_W-1:0]   r_scanCol;
   logic               r_hit;

   logic               w_moveReady;
   logic               w_accept;
   logic               w_idxInRange;
   logic [CELLS-1:0]   w_occBits;
   logic               w_occupied;
   logic               w_moveLegal;
   logic [CELLS-1:0]   w_moveMask;
   logic [CELLS-1:0]   w_moverBoard;
   logic               w_boardFull;
   logic               w_scanDone;
   logic               w_runR;
   logic               w_runD;
   logic               w_runDR;
   logic               w_runDL;
   logic               w_cellHit;

   // Out-of-board coordinates read as empty, which also enforces the direction fit limits.
   function automatic logic cellAt(input logic [CELLS-1:0] b, input int r, input int c);
      logic [CELLS-1:0] t;
      t = '0;
      if (r < 0 || r >= N || c < 0 || c >= N) begin
         return 1'b0;
      end
      t = b >> (r*N + c);
      return t[0];
   endfunction

   assign w_moveReady  = (r_state == S_IDLE) && !bus.new_game;
   assign w_accept     = bus.move_valid && w_moveReady;
   assign w_idxInRange = (32'(bus.move_idx) < 32'(CELLS));
   assign w_occBits    = (r_xBoard | r_oBoard) >> bus.move_idx;
   assign w_occupied   = w_occBits[0];
   assign w_moveLegal  = w_idxInRange && !w_occupied;
   assign w_moveMask   = {{(CELLS-1){1'b0}}, 1'b1} << bus.move_idx;
   assign w_moverBoard = r_turn ? r_xBoard : r_oBoard;
   assign w_boardFull  = &(r_xBoard | r_oBoard);
   assign w_scanDone   = (r_scanCnt == CNT_W'(CELLS));

   always_comb begin
      int row;
      int col;
      row     = int'(r_scanRow);
      col     = int'(r_scanCol);
      w_runR  = 1'b1;
      w_runD  = 1'b1;
      w_runDR = 1'b1;
      w_runDL = 1'b1;
      for (int d = 0; d < K; d++) begin
         w_runR  = w_runR  & cellAt(w_moverBoard, row,     col + d);
         w_runD  = w_runD  & cellAt(w_moverBoard, row + d, col);
         w_runDR = w_runDR & cellAt(w_moverBoard, row + d, col + d);
         w_runDL = w_runDL & cellAt(w_moverBoard, row + d, col - d);
      end
      w_cellHit = !w_scanDone && (w_runR || w_runD || w_runDR || w_runDL);
   end

   // new_game outranks every state so an in-flight scan is dropped without reporting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_xBoard      <= '0;
         r_oBoard      <= '0;
         r_turn        <= FIRST_PLAYER;
         r_status      <= ST_PLAY;
         r_statusValid <= 1'b0;
         r_xWins       <= '0;
         r_oWins       <= '0;
         r_scanCnt     <= '0;
         r_scanRow     <= '0;
         r_scanCol     <= '0;
         r_hit         <= 1'b0;
      end else begin
         r_statusValid <= 1'b0;
         if (bus.new_game) begin
            r_state   <= S_IDLE;
            r_xBoard  <= '0;
            r_oBoard  <= '0;
            r_turn    <= FIRST_PLAYER;
            r_status  <= ST_PLAY;
            r_scanCnt <= '0;
            r_scanRow <= '0;
            r_scanCol <= '0;
            r_hit     <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     if (w_moveLegal) begin
                        if (r_turn) begin
                           r_xBoard <= r_xBoard | w_moveMask;
                        end else begin
                           r_oBoard <= r_oBoard | w_moveMask;
                        end
                        r_state   <= S_CHECK;
                        r_scanCnt <= '0;
                        r_scanRow <= '0;
                        r_scanCol <= '0;
                        r_hit     <= 1'b0;
                     end else begin
                        r_status      <= ST_BAD;
                        r_statusValid <= 1'b1;
                     end
                  end
               end
               S_CHECK: begin
                  if (!w_scanDone) begin
                     r_hit     <= r_hit | w_cellHit;
                     r_scanCnt <= r_scanCnt + 1'b1;
                     if (r_scanCol == CNT_W'(N-1)) begin
                        r_scanCol <= '0;
                        r_scanRow <= r_scanRow + 1'b1;
                     end else begin
                        r_scanCol <= r_scanCol + 1'b1;
                     end
                  end else begin
                     // A hit takes precedence so the filling move can still win.
                     r_statusValid <= 1'b1;
                     if (r_hit) begin
                        r_state <= S_OVER;
                        if (r_turn) begin
                           r_status <= ST_XWIN;
                           if (r_xWins != {SCORE_W{1'b1}}) begin
                              r_xWins <= r_xWins + 1'b1;
                           end
                        end else begin
                           r_status <= ST_OWIN;
                           if (r_oWins != {SCORE_W{1'b1}}) begin
                              r_oWins <= r_oWins + 1'b1;
                           end
                        end
                     end else if (w_boardFull) begin
                        r_state  <= S_OVER;
                        r_status <= ST_DRAW;
                     end else begin
                        r_state  <= S_IDLE;
                        r_status <= ST_PLAY;
                        r_turn   <= ~r_turn;
                     end
                  end
               end
               S_OVER: begin
                  r_state <= S_OVER;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.move_ready   = w_moveReady;
   assign bus.x_board      = r_xBoard;
   assign bus.o_board      = r_oBoard;
   assign bus.turn         = r_turn;
   assign bus.status       = r_status;
   assign bus.status_valid = r_statusValid;
   assign bus.x_wins       = r_xWins;
   assign bus.o_wins       = r_oWins;

endmodule
